// File: rtl/n_serial_rx_decoder_pkg.sv
// Shared N-serial receive definitions: decoder state encoding and 25 MHz timing defaults.
`default_nettype none

package n_serial_rx_decoder_pkg;

  typedef enum logic [1:0] {
    NSR_RESYNC = 2'd0,
    NSR_IDLE   = 2'd1,
    NSR_BIT    = 2'd2
  } nsr_state_t;

  // Defaults at 25 MHz, kept in step with the transmit timebase.
  localparam int NS_SAMPLE_CYCLES  = 50;
  localparam int NS_IDLE_CYCLES    = 150;
  localparam int NS_MAX_LOW_CYCLES = 125;
  localparam int NS_CNT_W          = 8;

endpackage

`default_nettype wire

// File: rtl/n_serial_rx_sync.sv
// Line synchronizer, optional glitch filter (N_SERIAL_GLITCH_FILTER_EN) and falling-edge detector.
`default_nettype none

module n_serial_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic meta;
  logic sync;
  logic rx_s_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= rx;
      sync <= meta;
    end
  end

`ifdef N_SERIAL_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic       held;
  logic       all_eq;

  // Output follows the line only once three consecutive samples agree.
  assign all_eq = (sync == hist[0]) && (hist[0] == hist[1]);
  assign rx_s   = all_eq ? sync : held;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= 2'b00;
      held <= 1'b0;
    end else begin
      hist <= {hist[0], sync};
      held <= rx_s;
    end
  end
`else
  assign rx_s = sync;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s_q <= 1'b0;
    end else begin
      rx_s_q <= rx_s;
    end
  end

  assign fall = rx_s_q & ~rx_s;

endmodule

`default_nettype wire

// File: rtl/n_serial_rx_decoder.sv
// N-serial receive bit decoder: pulse-width-coded line to start/strobe/data/stop/error pulses.
// Glitch filtering in the sync stage is enabled by defining N_SERIAL_GLITCH_FILTER_EN.
`default_nettype none

module n_serial_rx_decoder
  import n_serial_rx_decoder_pkg::*;
#(
  parameter int SAMPLE_CYCLES  = NS_SAMPLE_CYCLES,
  parameter int IDLE_CYCLES    = NS_IDLE_CYCLES,
  parameter int MAX_LOW_CYCLES = NS_MAX_LOW_CYCLES,
  parameter int CNT_W          = NS_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_start,
  output logic rx_strobe,
  output logic rx_data,
  output logic rx_stop,
  output logic rx_error
);

  localparam logic [CNT_W-1:0] SAMPLE_AT   = CNT_W'(SAMPLE_CYCLES);
  localparam logic [CNT_W-1:0] IDLE_AT     = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] MAX_LOW_AT  = CNT_W'(MAX_LOW_CYCLES);

  logic             rx_s;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic             pend_v;
  logic             pend_d;
  nsr_state_t       state;

  n_serial_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  // While resynchronising, a low line restarts the idle measurement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (fall || (state == NSR_RESYNC && !rx_s)) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= NSR_RESYNC;
      pend_v    <= 1'b0;
      pend_d    <= 1'b0;
      rx_start  <= 1'b0;
      rx_strobe <= 1'b0;
      rx_data   <= 1'b0;
      rx_stop   <= 1'b0;
      rx_error  <= 1'b0;
    end else begin
      rx_start  <= 1'b0;
      rx_strobe <= 1'b0;
      rx_stop   <= 1'b0;
      rx_error  <= 1'b0;
      case (state)
        NSR_RESYNC: begin
          if (rx_s && cnt >= IDLE_AT) begin
            state <= NSR_IDLE;
          end
        end
        NSR_IDLE: begin
          if (fall) begin
            rx_start <= 1'b1;
            pend_v   <= 1'b0;
            state    <= NSR_BIT;
          end
        end
        NSR_BIT: begin
          // An edge always takes priority over a coincident sample or timeout.
          if (fall) begin
            if (pend_v) begin
              rx_strobe <= 1'b1;
              rx_data   <= pend_d;
              pend_v    <= 1'b0;
            end else begin
              rx_error <= 1'b1;
              state    <= NSR_RESYNC;
            end
          end else if (cnt == SAMPLE_AT) begin
            pend_d <= rx_s;
            pend_v <= 1'b1;
          end else if (!rx_s && cnt == MAX_LOW_AT) begin
            rx_error <= 1'b1;
            state    <= NSR_RESYNC;
          end else if (rx_s && cnt == IDLE_AT) begin
            // Only a pending '1' is a stop bit; a trailing '0' is a broken frame.
            if (pend_v && pend_d) begin
              rx_stop <= 1'b1;
            end else begin
              rx_error <= 1'b1;
            end
            state <= NSR_IDLE;
          end
        end
        default: begin
          state <= NSR_RESYNC;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_n_serial_rx_decoder.sv
// Directed scoreboard bench for n_serial_rx_decoder (default and glitch-filter builds).
`timescale 1ns/1ps
`default_nettype none

module tb_n_serial_rx_decoder;

  localparam int IDLE = 150;
  localparam int MAXL = 125;
`ifdef N_SERIAL_GLITCH_FILTER_EN
  localparam int LAT  = 4;
  localparam bit FILT = 1'b1;
`else
  localparam int LAT  = 2;
  localparam bit FILT = 1'b0;
`endif

  localparam int EV_START  = 0;
  localparam int EV_STROBE = 1;
  localparam int EV_STOP   = 2;
  localparam int EV_ERROR  = 3;

  typedef struct {
    int kind;
    bit data;
    int at;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b1;
  logic rx_start, rx_strobe, rx_data, rx_stop, rx_error;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  q[$];

  n_serial_rx_decoder #(
    .SAMPLE_CYCLES  (50),
    .IDLE_CYCLES    (IDLE),
    .MAX_LOW_CYCLES (MAXL),
    .CNT_W          (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_start  (rx_start),
    .rx_strobe (rx_strobe),
    .rx_data   (rx_data),
    .rx_stop   (rx_stop),
    .rx_error  (rx_error)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line changes just after posedge c; an event is expected visible at cycle index 'at'.
  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(input int kind, input bit data, input int at);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.at   = at;
    q.push_back(e);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // MSB first; glitch_bit (a '1' bit) gets a 1-cycle low spike 5 cycles into its high phase.
  task automatic send_frame(input logic [7:0] val, input int nbits, input bit with_stop,
                            input int glitch_bit);
    bit aborted;
    bit b;
    bit prev_b;
    int f;
    int f_last;
    aborted = 1'b0;
    prev_b  = 1'b0;
    f_last  = cyc;
    for (int k = 0; k < nbits; k++) begin
      b = val[nbits-1-k];
      f = cyc;
      f_last = f;
      if (!aborted) begin
        if (k == 0) expect_ev(EV_START, 1'b0, f + LAT + 1);
        else        expect_ev(EV_STROBE, prev_b, f + LAT + 1);
      end
      if (b) begin
        if (k == glitch_bit) begin
          drive(1'b0, 25);
          drive(1'b1, 5);
          if (!FILT && !aborted) begin
            expect_ev(EV_ERROR, 1'b0, f + 30 + LAT + 1);
            aborted = 1'b1;
          end
          drive(1'b0, 1);
          drive(1'b1, 69);
        end else begin
          drive(1'b0, 25);
          drive(1'b1, 75);
        end
      end else begin
        drive(1'b0, 75);
        drive(1'b1, 25);
      end
      prev_b = b;
    end
    if (with_stop) begin
      f = cyc;
      if (!aborted) begin
        expect_ev(EV_STROBE, prev_b, f + LAT + 1);
        expect_ev(EV_STOP, 1'b0, f + IDLE + LAT + 2);
      end
      drive(1'b0, 25);
      drive(1'b1, IDLE + 50);
    end else begin
      if (!aborted) expect_ev(EV_ERROR, 1'b0, f_last + IDLE + LAT + 2);
      drive(1'b1, IDLE + 50);
    end
  endtask

  always @(negedge clk) begin : monitor
    int  n;
    int  kind;
    ev_t e;
    n = int'(rx_start) + int'(rx_strobe) + int'(rx_stop) + int'(rx_error);
    if (n > 0) begin
      checks++;
      assert (n == 1)
      else begin
        errors++;
        $error("FAIL one_pulse observed %0d expected 1 at cyc %0d", n, cyc);
      end
      kind = rx_start ? EV_START : rx_strobe ? EV_STROBE : rx_stop ? EV_STOP : EV_ERROR;
      checks++;
      assert (q.size() != 0)
      else begin
        errors++;
        $error("FAIL unexpected_pulse observed kind %0d expected none at cyc %0d", kind, cyc);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        assert (kind === e.kind)
        else begin
          errors++;
          $error("FAIL pulse_kind observed %0d expected %0d at cyc %0d", kind, e.kind, cyc);
        end
        checks++;
        assert (cyc === e.at)
        else begin
          errors++;
          $error("FAIL pulse_time observed %0d expected %0d kind %0d", cyc, e.at, e.kind);
        end
        if (kind == EV_STROBE) begin
          checks++;
          assert (rx_data === e.data)
          else begin
            errors++;
            $error("FAIL strobe_data observed %b expected %b at cyc %0d", rx_data, e.data, cyc);
          end
        end
      end
    end
  end

  initial begin : stim
    int f;
    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_bit("reset_start", rx_start, 1'b0);
    check_bit("reset_strobe", rx_strobe, 1'b0);
    check_bit("reset_data", rx_data, 1'b0);
    check_bit("reset_stop", rx_stop, 1'b0);
    check_bit("reset_error", rx_error, 1'b0);
    reset = 1'b1;
    drive(1'b1, 200);

    // Clean byte 0x41 with stop, then a frame that ends on a '0'.
    send_frame(8'h41, 8, 1'b1, -1);
    send_frame(8'h40, 8, 1'b0, -1);

    // Over-long low, then activity that must be ignored until the line has idled.
    f = cyc;
    expect_ev(EV_START, 1'b0, f + LAT + 1);
    expect_ev(EV_ERROR, 1'b0, f + MAXL + LAT + 2);
    drive(1'b0, 130);
    drive(1'b1, 50);
    drive(1'b0, 25);
    drive(1'b1, 25);
    drive(1'b0, 25);
    drive(1'b1, IDLE + 20);
    send_frame(8'h05, 3, 1'b1, -1);

    // Runt bit: second edge 30 cycles after the first.
    f = cyc;
    expect_ev(EV_START, 1'b0, f + LAT + 1);
    expect_ev(EV_ERROR, 1'b0, f + 30 + LAT + 1);
    drive(1'b0, 10);
    drive(1'b1, 20);
    drive(1'b0, 25);
    drive(1'b1, IDLE + 50);

    // Reset mid-byte with the line low, released while still low.
    f = cyc;
    expect_ev(EV_START, 1'b0, f + LAT + 1);
    drive(1'b0, 75);
    drive(1'b1, 25);
    f = cyc;
    expect_ev(EV_STROBE, 1'b0, f + LAT + 1);
    drive(1'b0, 25);
    drive(1'b1, 75);
    f = cyc;
    expect_ev(EV_STROBE, 1'b1, f + LAT + 1);
    drive(1'b0, 10);
    check_bit("data_held", rx_data, 1'b1);
    reset = 1'b0;
    #1;
    check_bit("midreset_data", rx_data, 1'b0);
    check_bit("midreset_strobe", rx_strobe, 1'b0);
    drive(1'b0, 20);
    reset = 1'b1;
    drive(1'b0, 40);
    drive(1'b1, 100);
    drive(1'b0, 25);
    drive(1'b1, IDLE + 20);
    send_frame(8'h01, 1, 1'b1, -1);

    // 1-cycle glitch inside a '1' high phase.
    send_frame(8'h41, 8, 1'b1, 1);

    for (int i = 0; i < 1000 && q.size() != 0; i++) @(posedge clk);
    checks++;
    assert (q.size() == 0)
    else begin
      errors++;
      $error("FAIL missing_pulses observed %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
